mc_ctrl_fsm: RTL and testbench

- Multi-cycle control unit for the 31-instruction MIPS core; sits directly upstream of the ALU.
- Fetches and latches the instruction and decodes it.
- Drives the 5-bit aluc code, the operand selects, and the PC/regfile/memory strobes.
- Sequences IF/ID/EX/MEM/WB and consumes the ALU zero flag for branch resolution.

---
 rtl/mc_ctrl_if.sv | 38 +++
 rtl/mc_ctrl_fsm.sv | 233 +++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// Control-unit bus: instruction/data memory handshakes, ALU/PC/regfile controls and status.
interface mc_ctrl_if #(
    parameter int unsigned RETIRE_W = 32
);
    logic [31:0]         imem_rdata;
    logic                imem_ready;
    logic                imem_req;
    logic                dmem_ready;
    logic                dmem_req;
    logic                dmem_we;
    logic                alu_zero;
    logic [4:0]          aluc;
    logic [1:0]          a_sel;
    logic [1:0]          b_sel;
    logic                pc_we;
    logic [1:0]          pc_sel;
    logic                reg_we;
    logic [1:0]          dst_sel;
    logic [1:0]          wb_sel;
    logic [31:0]         ir;
    logic [2:0]          state;
    logic                illegal;
    logic [RETIRE_W-1:0] retired;

    // Controller side
    modport master (
        input  imem_rdata, imem_ready, dmem_ready, alu_zero,
        output imem_req, dmem_req, dmem_we, aluc, a_sel, b_sel, pc_we, pc_sel,
               reg_we, dst_sel, wb_sel, ir, state, illegal, retired
    );

    // Datapath / memory side
    modport slave (
        output imem_rdata, imem_ready, dmem_ready, alu_zero,
        input  imem_req, dmem_req, dmem_we, aluc, a_sel, b_sel, pc_we, pc_sel,
               reg_we, dst_sel, wb_sel, ir, state, illegal, retired
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle IF/ID/EX/MEM/WB controller for the 31-instruction MIPS core.
// Latches the instruction, decodes it to an ALU code and drives PC/regfile/memory strobes.
module mc_ctrl_fsm #(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    mc_ctrl_if.master  bus
);
    typedef enum logic [2:0] {
        S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4
    } state_e;

    typedef enum logic [4:0] {
        OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV,
        OP_JR, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW,
        OP_BEQ, OP_BNE, OP_SLTI, OP_SLTIU, OP_LUI, OP_J, OP_JAL
    } alu_op_e;

    state_e              state_q, state_d;
    logic [31:0]         ir_q, ir_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;

    logic [5:0] opcode, funct;
    logic       is_rtype, dec_valid;
    alu_op_e    op_dec;
    logic [1:0] alu_a, alu_b;

    logic       imem_req, dmem_req, dmem_we, pc_we, reg_we, illegal;
    logic [4:0] aluc;
    logic [1:0] a_sel, b_sel, pc_sel, dst_sel, wb_sel;

    assign opcode   = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign is_rtype = (opcode == 6'b000000);

    // Instruction decode from the latched word
    always_comb begin
        dec_valid = 1'b1;
        op_dec    = OP_ADD;
        if (is_rtype) begin
            case (funct)
                6'b100000: op_dec = OP_ADD;
                6'b100001: op_dec = OP_ADDU;
                6'b100010: op_dec = OP_SUB;
                6'b100011: op_dec = OP_SUBU;
                6'b100100: op_dec = OP_AND;
                6'b100101: op_dec = OP_OR;
                6'b100110: op_dec = OP_XOR;
                6'b100111: op_dec = OP_NOR;
                6'b101010: op_dec = OP_SLT;
                6'b101011: op_dec = OP_SLTU;
                6'b000000: op_dec = OP_SLL;
                6'b000010: op_dec = OP_SRL;
                6'b000011: op_dec = OP_SRA;
                6'b000100: op_dec = OP_SLLV;
                6'b000110: op_dec = OP_SRLV;
                6'b000111: op_dec = OP_SRAV;
                6'b001000: op_dec = OP_JR;
                default:   dec_valid = 1'b0;
            endcase
        end else begin
            case (opcode)
                6'b001000: op_dec = OP_ADDI;
                6'b001001: op_dec = OP_ADDIU;
                6'b001100: op_dec = OP_ANDI;
                6'b001101: op_dec = OP_ORI;
                6'b001110: op_dec = OP_XORI;
                6'b100011: op_dec = OP_LW;
                6'b101011: op_dec = OP_SW;
                6'b000100: op_dec = OP_BEQ;
                6'b000101: op_dec = OP_BNE;
                6'b001010: op_dec = OP_SLTI;
                6'b001011: op_dec = OP_SLTIU;
                6'b001111: op_dec = OP_LUI;
                6'b000010: op_dec = OP_J;
                6'b000011: op_dec = OP_JAL;
                default:   dec_valid = 1'b0;
            endcase
        end
    end

    // ALU operand selects, held constant while the instruction is in EX/MEM/WB
    always_comb begin
        alu_a = 2'd0;
        alu_b = 2'd0;
        if (op_dec inside {OP_SLL, OP_SRL, OP_SRA})
            alu_a = 2'd1;
        if (op_dec inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW})
            alu_b = 2'd1;
        else if (op_dec inside {OP_ANDI, OP_ORI, OP_XORI, OP_LUI})
            alu_b = 2'd2;
    end

    // Next-state and control outputs
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        reg_we    = 1'b0;
        illegal   = 1'b0;
        aluc      = 5'd0;
        a_sel     = 2'd0;
        b_sel     = 2'd0;
        pc_sel    = 2'd0;
        dst_sel   = 2'd0;
        wb_sel    = 2'd0;

        case (state_q)
            S_IF: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_d    = bus.imem_rdata;
                    pc_we   = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                if (!dec_valid) begin
                    illegal = 1'b1;
                    state_d = S_IF;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                aluc  = op_dec;
                a_sel = alu_a;
                b_sel = alu_b;
                case (op_dec)
                    OP_BEQ, OP_BNE: begin
                        if ((op_dec == OP_BEQ) == bus.alu_zero) begin
                            pc_we  = 1'b1;
                            pc_sel = 2'd1;
                        end
                        state_d = S_IF;
                    end
                    OP_J: begin
                        pc_we   = 1'b1;
                        pc_sel  = 2'd2;
                        state_d = S_IF;
                    end
                    OP_JR: begin
                        pc_we   = 1'b1;
                        pc_sel  = 2'd3;
                        state_d = S_IF;
                    end
                    OP_JAL: begin
                        pc_we   = 1'b1;
                        pc_sel  = 2'd2;
                        reg_we  = 1'b1;
                        dst_sel = 2'd2;
                        wb_sel  = 2'd2;
                        state_d = S_IF;
                    end
                    OP_LW, OP_SW: state_d = S_MEM;
                    default:      state_d = S_WB;
                endcase
            end
            S_MEM: begin
                aluc     = op_dec;
                a_sel    = alu_a;
                b_sel    = alu_b;
                dmem_req = 1'b1;
                dmem_we  = (op_dec == OP_SW);
                if (bus.dmem_ready)
                    state_d = (op_dec == OP_SW) ? S_IF : S_WB;
            end
            S_WB: begin
                aluc    = op_dec;
                a_sel   = alu_a;
                b_sel   = alu_b;
                reg_we  = 1'b1;
                dst_sel = is_rtype ? 2'd0 : 2'd1;
                wb_sel  = (op_dec == OP_LW) ? 2'd1 : 2'd0;
                state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase

        // Only a completed instruction counts; the illegal path exits from ID
        if ((state_q inside {S_EX, S_MEM, S_WB}) && (state_d == S_IF))
            retired_d = retired_q + RETIRE_W'(1);

        if (rst) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            pc_we    = 1'b0;
            reg_we   = 1'b0;
            illegal  = 1'b0;
            aluc     = 5'd0;
            a_sel    = 2'd0;
            b_sel    = 2'd0;
            pc_sel   = 2'd0;
            dst_sel  = 2'd0;
            wb_sel   = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IF;
            ir_q      <= 32'd0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    assign bus.imem_req = imem_req;
    assign bus.dmem_req = dmem_req;
    assign bus.dmem_we  = dmem_we;
    assign bus.aluc     = aluc;
    assign bus.a_sel    = a_sel;
    assign bus.b_sel    = b_sel;
    assign bus.pc_we    = pc_we;
    assign bus.pc_sel   = pc_sel;
    assign bus.reg_we   = reg_we;
    assign bus.dst_sel  = dst_sel;
    assign bus.wb_sel   = wb_sel;
    assign bus.ir       = ir_q;
    assign bus.state    = state_q;
    assign bus.illegal  = illegal;
    assign bus.retired  = retired_q;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-scenario tasks with hand-computed expectations.
module tb_mc_ctrl_fsm;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [31:0] exp_ret;

    mc_ctrl_if #(.RETIRE_W(32)) bus ();

    mc_ctrl_fsm #(.RETIRE_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one instruction word in IF; returns at the negedge of the ID cycle
    task automatic fetch(input logic [31:0] instr);
        bus.imem_rdata = instr;
        bus.imem_ready = 1'b1;
        #1;
        checks++;
        if (bus.state !== 3'd0 || bus.imem_req !== 1'b1 || bus.pc_we !== 1'b1 || bus.pc_sel !== 2'd0) begin
            failures++;
            $display("FAIL fetch_%h got state=%0d imem_req=%b pc_we=%b pc_sel=%0d want 0/1/1/0",
                     instr, bus.state, bus.imem_req, bus.pc_we, bus.pc_sel);
        end
        tick();
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h0109_5020;
        tick();
        tick();
        #1;
        checks++;
        if (bus.state !== 3'd0 || bus.ir !== 32'd0 || bus.retired !== 32'd0) begin
            failures++;
            $display("FAIL reset_regs got state=%0d ir=%h retired=%0d want 0/0/0",
                     bus.state, bus.ir, bus.retired);
        end
        checks++;
        if (bus.imem_req !== 1'b0 || bus.pc_we !== 1'b0 || bus.aluc !== 5'd0 || bus.reg_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes got imem_req=%b pc_we=%b aluc=%0d reg_we=%b want 0/0/0/0",
                     bus.imem_req, bus.pc_we, bus.aluc, bus.reg_we);
        end
        bus.imem_ready = 1'b0;
        rst = 1'b0;
        tick();
        #1;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.pc_we !== 1'b0) begin
            failures++;
            $display("FAIL if_idle got imem_req=%b pc_we=%b want 1/0", bus.imem_req, bus.pc_we);
        end
        exp_ret = 32'd0;
    endtask

    task automatic test_add();
        fetch(32'h0109_5020);
        checks++;
        if (bus.state !== 3'd1 || bus.ir !== 32'h0109_5020 || bus.illegal !== 1'b0) begin
            failures++;
            $display("FAIL add_id got state=%0d ir=%h illegal=%b want 1/01095020/0",
                     bus.state, bus.ir, bus.illegal);
        end
        tick(); #1;
        checks++;
        if (bus.state !== 3'd2 || bus.aluc !== 5'd0 || bus.a_sel !== 2'd0 || bus.b_sel !== 2'd0 || bus.pc_we !== 1'b0) begin
            failures++;
            $display("FAIL add_ex got state=%0d aluc=%0d a=%0d b=%0d pc_we=%b want 2/0/0/0/0",
                     bus.state, bus.aluc, bus.a_sel, bus.b_sel, bus.pc_we);
        end
        tick(); #1;
        checks++;
        if (bus.state !== 3'd4 || bus.reg_we !== 1'b1 || bus.dst_sel !== 2'd0 || bus.wb_sel !== 2'd0) begin
            failures++;
            $display("FAIL add_wb got state=%0d reg_we=%b dst=%0d wb=%0d want 4/1/0/0",
                     bus.state, bus.reg_we, bus.dst_sel, bus.wb_sel);
        end
        tick(); #1;
        exp_ret = exp_ret + 32'd1;
        checks++;
        if (bus.state !== 3'd0 || bus.retired !== exp_ret) begin
            failures++;
            $display("FAIL add_retire got state=%0d retired=%0d want 0/%0d", bus.state, bus.retired, exp_ret);
        end
    endtask

    task automatic test_lw_stall();
        fetch(32'h8D09_0004);
        tick(); #1;
        checks++;
        if (bus.state !== 3'd2 || bus.aluc !== 5'b10110 || bus.b_sel !== 2'd1) begin
            failures++;
            $display("FAIL lw_ex got state=%0d aluc=%b b=%0d want 2/10110/1", bus.state, bus.aluc, bus.b_sel);
        end
        bus.dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            checks++;
            if (bus.state !== 3'd3 || bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b0 ||
                bus.aluc !== 5'b10110 || bus.b_sel !== 2'd1) begin
                failures++;
                $display("FAIL lw_mem_wait%0d got state=%0d req=%b we=%b aluc=%b b=%0d want 3/1/0/10110/1",
                         i, bus.state, bus.dmem_req, bus.dmem_we, bus.aluc, bus.b_sel);
            end
        end
        bus.dmem_ready = 1'b1;
        tick();
        bus.dmem_ready = 1'b0;
        #1;
        checks++;
        if (bus.state !== 3'd4 || bus.reg_we !== 1'b1 || bus.wb_sel !== 2'd1 || bus.dst_sel !== 2'd1) begin
            failures++;
            $display("FAIL lw_wb got state=%0d reg_we=%b wb=%0d dst=%0d want 4/1/1/1",
                     bus.state, bus.reg_we, bus.wb_sel, bus.dst_sel);
        end
        tick(); #1;
        exp_ret = exp_ret + 32'd1;
        checks++;
        if (bus.state !== 3'd0 || bus.retired !== exp_ret) begin
            failures++;
            $display("FAIL lw_retire got state=%0d retired=%0d want 0/%0d", bus.state, bus.retired, exp_ret);
        end
    endtask

    task automatic test_beq();
        logic [1:0] zero_vals;
        zero_vals = 2'b01;
        for (int k = 0; k < 2; k++) begin
            fetch(32'h1109_0003);
            tick();
            bus.alu_zero = zero_vals[k];
            #1;
            checks++;
            if (bus.state !== 3'd2 || bus.aluc !== 5'd24 || bus.b_sel !== 2'd0 ||
                bus.pc_we !== zero_vals[k] || bus.pc_sel !== (zero_vals[k] ? 2'd1 : 2'd0)) begin
                failures++;
                $display("FAIL beq_ex_z%0d got state=%0d aluc=%0d b=%0d pc_we=%b pc_sel=%0d want 2/24/0/%b/%0d",
                         zero_vals[k], bus.state, bus.aluc, bus.b_sel, bus.pc_we, bus.pc_sel,
                         zero_vals[k], zero_vals[k] ? 1 : 0);
            end
            tick();
            bus.alu_zero = 1'b0;
            #1;
            exp_ret = exp_ret + 32'd1;
            checks++;
            if (bus.state !== 3'd0 || bus.retired !== exp_ret) begin
                failures++;
                $display("FAIL beq_retire_z%0d got state=%0d retired=%0d want 0/%0d",
                         zero_vals[k], bus.state, bus.retired, exp_ret);
            end
        end
    endtask

    task automatic test_jal();
        fetch(32'h0C00_0010);
        tick(); #1;
        checks++;
        if (bus.state !== 3'd2 || bus.aluc !== 5'd30 || bus.pc_we !== 1'b1 || bus.pc_sel !== 2'd2 ||
            bus.reg_we !== 1'b1 || bus.dst_sel !== 2'd2 || bus.wb_sel !== 2'd2) begin
            failures++;
            $display("FAIL jal_ex got state=%0d aluc=%0d pc_we=%b pc_sel=%0d reg_we=%b dst=%0d wb=%0d want 2/30/1/2/1/2/2",
                     bus.state, bus.aluc, bus.pc_we, bus.pc_sel, bus.reg_we, bus.dst_sel, bus.wb_sel);
        end
        tick(); #1;
        exp_ret = exp_ret + 32'd1;
        checks++;
        if (bus.state !== 3'd0 || bus.retired !== exp_ret) begin
            failures++;
            $display("FAIL jal_retire got state=%0d retired=%0d want 0/%0d", bus.state, bus.retired, exp_ret);
        end
    endtask

    // EX-stage decode of assorted opcodes; wb marks instructions that go on to WB
    task automatic test_decode();
        logic [31:0] instr  [8] = '{32'h0009_4080, 32'h3509_0005, 32'h0100_0008, 32'h0800_0010,
                                    32'h1509_0003, 32'h0109_502A, 32'h3C09_1234, 32'h0109_5007};
        logic [4:0]  e_aluc [8] = '{5'd10, 5'd20, 5'd16, 5'd29, 5'd25, 5'd8, 5'd28, 5'd15};
        logic [1:0]  e_a    [8] = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        logic [1:0]  e_b    [8] = '{2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0};
        logic        e_pcwe [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0]  e_pcs  [8] = '{2'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
        logic        e_wb   [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0]  e_dst  [8] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
        for (int i = 0; i < 8; i++) begin
            fetch(instr[i]);
            tick();
            bus.alu_zero = 1'b0;
            #1;
            checks++;
            if (bus.state !== 3'd2 || bus.aluc !== e_aluc[i] || bus.a_sel !== e_a[i] || bus.b_sel !== e_b[i] ||
                bus.pc_we !== e_pcwe[i] || bus.pc_sel !== e_pcs[i]) begin
                failures++;
                $display("FAIL dec_ex_%h got state=%0d aluc=%0d a=%0d b=%0d pc_we=%b pc_sel=%0d want 2/%0d/%0d/%0d/%b/%0d",
                         instr[i], bus.state, bus.aluc, bus.a_sel, bus.b_sel, bus.pc_we, bus.pc_sel,
                         e_aluc[i], e_a[i], e_b[i], e_pcwe[i], e_pcs[i]);
            end
            tick(); #1;
            if (e_wb[i]) begin
                checks++;
                if (bus.state !== 3'd4 || bus.reg_we !== 1'b1 || bus.dst_sel !== e_dst[i] || bus.wb_sel !== 2'd0) begin
                    failures++;
                    $display("FAIL dec_wb_%h got state=%0d reg_we=%b dst=%0d wb=%0d want 4/1/%0d/0",
                             instr[i], bus.state, bus.reg_we, bus.dst_sel, bus.wb_sel, e_dst[i]);
                end
                tick(); #1;
            end
            exp_ret = exp_ret + 32'd1;
            checks++;
            if (bus.state !== 3'd0 || bus.retired !== exp_ret) begin
                failures++;
                $display("FAIL dec_retire_%h got state=%0d retired=%0d want 0/%0d",
                         instr[i], bus.state, bus.retired, exp_ret);
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad [2] = '{32'hFC00_0000, 32'h0000_0001};
        for (int i = 0; i < 2; i++) begin
            fetch(bad[i]);
            checks++;
            if (bus.state !== 3'd1 || bus.illegal !== 1'b1) begin
                failures++;
                $display("FAIL illegal_id_%h got state=%0d illegal=%b want 1/1", bad[i], bus.state, bus.illegal);
            end
            tick(); #1;
            checks++;
            if (bus.state !== 3'd0 || bus.illegal !== 1'b0 || bus.retired !== exp_ret) begin
                failures++;
                $display("FAIL illegal_exit_%h got state=%0d illegal=%b retired=%0d want 0/0/%0d",
                         bad[i], bus.state, bus.illegal, bus.retired, exp_ret);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        fetch(32'hAD09_0004);
        bus.dmem_ready = 1'b0;
        tick();
        tick(); #1;
        checks++;
        if (bus.state !== 3'd3 || bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b1) begin
            failures++;
            $display("FAIL sw_mem got state=%0d req=%b we=%b want 3/1/1", bus.state, bus.dmem_req, bus.dmem_we);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0 || bus.state !== 3'd0 ||
            bus.ir !== 32'd0 || bus.retired !== 32'd0) begin
            failures++;
            $display("FAIL sw_rst got req=%b we=%b state=%0d ir=%h retired=%0d want 0/0/0/0/0",
                     bus.dmem_req, bus.dmem_we, bus.state, bus.ir, bus.retired);
        end
        tick();
        rst = 1'b0;
        exp_ret = 32'd0;
        tick(); #1;
        checks++;
        if (bus.state !== 3'd0 || bus.imem_req !== 1'b1) begin
            failures++;
            $display("FAIL post_rst got state=%0d imem_req=%b want 0/1", bus.state, bus.imem_req);
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        exp_ret        = 32'd0;
        rst            = 1'b1;
        bus.imem_rdata = 32'd0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.alu_zero   = 1'b0;
        @(negedge clk);
        test_reset();
        test_add();
        test_lw_stall();
        test_beq();
        test_jal();
        test_decode();
        test_illegal();
        test_reset_mid_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
